// File: rtl/dsd_pkg.sv
// Shared types and constants for the dot-product sequencer and its operand FIFO.
package dsd_pkg;

  localparam int unsigned OPERAND_W = 8;
  localparam int unsigned PRODUCT_W = 16;
  localparam int unsigned PAIR_W    = 2 * OPERAND_W + 1;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_EMIT  = 2'd3
  } state_e;

  // One FIFO entry: {last, x, y}
  typedef struct packed {
    logic                 last;
    logic [OPERAND_W-1:0] x;
    logic [OPERAND_W-1:0] y;
  } pair_t;

endpackage

// File: rtl/operand_fifo.sv
// Synchronous operand-pair FIFO, DEPTH entries of {last, x, y}.
// Ports:
//   clk, reset  - clock, async active-high reset
//   push_i      - write wdata_i (ignored when full, even if popping)
//   pop_i       - drop the head entry (ignored when empty)
//   wdata_i     - entry to write
//   head_o      - current head entry, read from the storage registers
//   full_o      - no free entries
//   empty_o     - no stored entries
module operand_fifo
  import dsd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push_i,
  input  logic  pop_i,
  input  pair_t wdata_i,
  output pair_t head_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  pair_t        mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB separates full from empty when the addresses match
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Storage and pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/dot_product_seq.sv
// Dot-product sequencer: buffers signed operand pairs, issues each pair to an
// external shift-and-add multiplier via start/done, accumulates the products
// and emits one result per vector (vector ends on in_last).
// Build option: DOT_PRODUCT_SAT_EN - clamp the accumulator instead of wrapping
// and report a sticky out_sat per vector.
// Ports:
//   clk, reset                 - clock, async active-high reset
//   in_valid/in_ready          - operand pair handshake (in_ready = !full)
//   in_x, in_y, in_last        - signed operands, end-of-vector marker
//   mul_start                  - one-cycle start pulse to the multiplier
//   mul_x, mul_y               - operands held stable from ISSUE to WAIT exit
//   mul_product, mul_done      - signed product, done level from multiplier
//   out_valid/out_ready        - result handshake
//   out_acc, out_count, out_sat- dot product, pair count mod 256, saturation
//   busy                       - not idle or FIFO not empty
module dot_product_seq
  import dsd_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ACC_W = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERAND_W-1:0] in_x,
  input  logic [OPERAND_W-1:0] in_y,
  input  logic                 in_last,
  output logic                 mul_start,
  output logic [OPERAND_W-1:0] mul_x,
  output logic [OPERAND_W-1:0] mul_y,
  input  logic [PRODUCT_W-1:0] mul_product,
  input  logic                 mul_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_acc,
  output logic [7:0]           out_count,
  output logic                 out_sat,
  output logic                 busy
);

  state_e                  state_q;
  logic [OPERAND_W-1:0]    mul_x_q;
  logic [OPERAND_W-1:0]    mul_y_q;
  logic                    last_q;
  logic                    mul_start_q;
  logic                    out_valid_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [7:0]              count_q;

  pair_t                   in_pair;
  pair_t                   head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_d;

  assign in_pair  = '{last: in_last, x: in_x, y: in_y};
  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

  operand_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (in_valid),
    .pop_i   (fifo_pop),
    .wdata_i (in_pair),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign prod_ext = ACC_W'($signed(mul_product));

`ifdef DOT_PRODUCT_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                  sat_q;
  logic signed [ACC_W:0] sum_wide;
  logic                  ovf;

  // One guard bit: overflow when the top two sum bits disagree
  assign sum_wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_ext);
  assign ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign acc_d    = ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX)
                        : sum_wide[ACC_W-1:0];
  assign out_sat  = sat_q;
`else
  assign acc_d    = acc_q + prod_ext;
  assign out_sat  = 1'b0;
`endif

  assign in_ready  = !fifo_full;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign mul_start = mul_start_q;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_count = count_q;

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      last_q      <= 1'b0;
      mul_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      count_q     <= '0;
`ifdef DOT_PRODUCT_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      mul_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            mul_x_q     <= head.x;
            mul_y_q     <= head.y;
            last_q      <= head.last;
            mul_start_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // Done is cleared by the multiplier on the ISSUE edge, so it is fresh here
          if (mul_done) begin
            acc_q   <= acc_d;
            count_q <= count_q + 8'd1;
`ifdef DOT_PRODUCT_SAT_EN
            sat_q   <= sat_q | ovf;
`endif
            if (last_q) begin
              out_valid_q <= 1'b1;
              state_q     <= ST_EMIT;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
`ifdef DOT_PRODUCT_SAT_EN
            sat_q       <= 1'b0;
`endif
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_seq.sv
// Self-checking bench for dot_product_seq with a behavioural shift-and-add
// multiplier partner and a result scoreboard.
module tb_dot_product_seq;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned ACC_W = 16;
  localparam longint      A_MAX = 32767;
  localparam longint      A_MIN = -32768;

  typedef struct {
    longint acc;
    longint cnt;
    longint sat;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_x = '0;
  logic [7:0]       in_y = '0;
  logic             in_last = 1'b0;
  logic             mul_start;
  logic [7:0]       mul_x;
  logic [7:0]       mul_y;
  logic [15:0]      mul_product;
  logic             mul_done;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_acc;
  logic [7:0]       out_count;
  logic             out_sat;
  logic             busy;

  int     total = 0;
  int     bad = 0;
  int     start_cnt = 0;
  int     lat_fixed = 0;
  int     mcnt = 0;
  exp_t   sb_q[$];
  longint m_acc = 0;
  longint m_cnt = 0;
  longint m_sat = 0;

  dot_product_seq #(
    .DEPTH (DEPTH),
    .ACC_W (ACC_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_last     (in_last),
    .mul_start   (mul_start),
    .mul_x       (mul_x),
    .mul_y       (mul_y),
    .mul_product (mul_product),
    .mul_done    (mul_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_acc     (out_acc),
    .out_count   (out_count),
    .out_sat     (out_sat),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Multiplier partner: done clears on start, rises after a variable latency;
  // y is taken at the final step, so the sequencer must hold its operands.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_done    <= 1'b0;
      mul_product <= '0;
      mcnt        <= 0;
    end else if (mul_start) begin
      mul_done <= 1'b0;
      mcnt     <= (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 12));
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mul_done    <= 1'b1;
        mul_product <= 16'($signed(mul_x) * $signed(mul_y));
      end
    end
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference accumulation, applied when a pair is accepted
  task automatic model_pair(input logic signed [7:0] x, input logic signed [7:0] y,
                            input logic last);
    longint s;
    s = m_acc + longint'(x) * longint'(y);
`ifdef DOT_PRODUCT_SAT_EN
    if (s > A_MAX) begin
      s = A_MAX;
      m_sat = 1;
    end else if (s < A_MIN) begin
      s = A_MIN;
      m_sat = 1;
    end
`else
    s = longint'($signed(ACC_W'(s)));
`endif
    m_acc = s;
    m_cnt = (m_cnt + 1) % 256;
    if (last) begin
      sb_q.push_back('{acc: m_acc, cnt: m_cnt, sat: m_sat});
      m_acc = 0;
      m_cnt = 0;
      m_sat = 0;
    end
  endtask

  // Offer one pair starting at a negedge; returns at the negedge after acceptance
  task automatic push_pair(input logic signed [7:0] x, input logic signed [7:0] y,
                           input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_last  = last;
    while (!in_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) begin
      check_eq("push_timeout", 1, 0);
    end else begin
      @(posedge clk);
      model_pair(x, y, last);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb_q.size() != 0 || busy || out_valid) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain_done", longint'(guard < 5000), 1);
  endtask

  // Scoreboard: compare on every result handshake
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("out_acc", longint'($signed(out_acc)), e.acc);
        check_eq("out_count", longint'(out_count), e.cnt);
        check_eq("out_sat", longint'(out_sat), e.sat);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && mul_start) start_cnt++;
  end

  initial begin
    int     s0;
    int     guard;
    longint acc0;
    longint cnt0;
    bit     stable;

    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", longint'(out_valid), 0);
    check_eq("rst_out_acc", longint'(out_acc), 0);
    check_eq("rst_mul_start", longint'(mul_start), 0);
    check_eq("rst_busy", longint'(busy), 0);
    check_eq("rst_in_ready", longint'(in_ready), 1);
    reset = 1'b0;
    @(negedge clk);

    // Basic vector: 12 - 30 + 16384 = 16366
    push_pair(8'sd3, 8'sd4, 1'b0);
    push_pair(-8'sd5, 8'sd6, 1'b0);
    push_pair(-8'sd128, -8'sd128, 1'b1);
    drain();

    // Single-pair vector with exactly one start pulse
    s0 = start_cnt;
    push_pair(-8'sd1, 8'sd127, 1'b1);
    drain();
    check_eq("single_starts", longint'(start_cnt - s0), 1);

    // Saturation / wrap at ACC_W = 16
    push_pair(-8'sd128, -8'sd128, 1'b0);
    push_pair(-8'sd128, -8'sd128, 1'b1);
    drain();

    // Backpressure in EMIT while the FIFO fills
    out_ready = 1'b0;
    push_pair(8'sd5, -8'sd7, 1'b0);
    push_pair(8'sd9, 8'sd3, 1'b1);
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("emit_reached", longint'(out_valid), 1);
    acc0   = longint'($signed(out_acc));
    cnt0   = longint'(out_count);
    s0     = start_cnt;
    stable = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      push_pair(8'(7 * (i + 1)), 8'(-3 * i - 1), 1'b0);
      if (longint'($signed(out_acc)) != acc0 || !out_valid) stable = 1'b0;
    end
    check_eq("fifo_full_in_ready", longint'(in_ready), 0);
    repeat (20 - DEPTH) begin
      @(negedge clk);
      if (longint'($signed(out_acc)) != acc0 || longint'(out_count) != cnt0 ||
          !out_valid) stable = 1'b0;
    end
    check_eq("emit_stable", longint'(stable), 1);
    check_eq("emit_no_start", longint'(start_cnt - s0), 0);
    out_ready = 1'b1;
    push_pair(8'sd11, 8'sd12, 1'b0);
    push_pair(-8'sd13, 8'sd14, 1'b1);
    drain();

    // A few random vectors
    for (int v = 0; v < 4; v++) begin
      int len;
      len = int'($urandom_range(1, 5));
      for (int p = 0; p < len; p++) begin
        push_pair(8'($urandom), 8'($urandom), 1'(p == len - 1));
      end
    end
    drain();

    // Reset during WAIT of the second pair discards the partial sum
    lat_fixed = 11;
    s0 = start_cnt;
    push_pair(8'sd10, 8'sd10, 1'b0);
    push_pair(8'sd3, 8'sd3, 1'b1);
    guard = 0;
    while (start_cnt < s0 + 2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("second_start_seen", longint'(start_cnt - s0), 2);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    m_acc = 0;
    m_cnt = 0;
    m_sat = 0;
    @(negedge clk);
    check_eq("midrst_out_acc", longint'(out_acc), 0);
    check_eq("midrst_out_count", longint'(out_count), 0);
    check_eq("midrst_mul_x", longint'(mul_x), 0);
    check_eq("midrst_busy", longint'(busy), 0);
    reset = 1'b0;
    @(negedge clk);
    lat_fixed = 0;
    push_pair(8'sd2, 8'sd2, 1'b1);
    drain();

    check_eq("sb_empty", longint'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
